axi_full_slv_mem: RTL and testbench

AXI4 full slave memory model for simulation benches and FPGA prototypes. It backs a byte-addressable SRAM of 2^AW words of DW bits. It is the parametrised successor of the existing single-channel SRAM slave, with these additions:
- read and write channels run concurrently and independently;
- FIXED, INCR and WRAP bursts, plus narrow (AxSIZE) transfers;
- AXI IDs;
- address-range checking with SLVERR responses.

---
 rtl/axi_full_slv_mem.sv | 276 +++++++++++++++++++++++++++
 tb/tb_axi_full_slv_mem.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_full_slv_mem.sv
`default_nettype none
// ============================================================================
//  Module   : axi_full_slv_mem
//  Brief    : AXI4 full slave backed by a 2^AW x DW byte-addressable SRAM.
//             Independent read/write channels, FIXED/INCR/WRAP bursts,
//             narrow transfers, ID echo and address-range SLVERR.
//  Revision : 1.0 - initial release
// ============================================================================
module axi_full_slv_mem #(
  parameter int          DW   = 64,
  parameter int          AW   = 14,
  parameter int          IW   = 4,
  parameter logic [31:0] BASE = 32'h8000_0000
) (
  input  logic            CLK,
  input  logic            RSTn,
  // write address
  input  logic [IW-1:0]   MEM_AWID,
  input  logic [31:0]     MEM_AWADDR,
  input  logic [7:0]      MEM_AWLEN,
  input  logic [2:0]      MEM_AWSIZE,
  input  logic [1:0]      MEM_AWBURST,
  input  logic            MEM_AWVALID,
  output logic            MEM_AWREADY,
  // write data
  input  logic [DW-1:0]   MEM_WDATA,
  input  logic [DW/8-1:0] MEM_WSTRB,
  input  logic            MEM_WLAST,
  input  logic            MEM_WVALID,
  output logic            MEM_WREADY,
  // write response
  output logic [IW-1:0]   MEM_BID,
  output logic [1:0]      MEM_BRESP,
  output logic            MEM_BVALID,
  input  logic            MEM_BREADY,
  // read address
  input  logic [IW-1:0]   MEM_ARID,
  input  logic [31:0]     MEM_ARADDR,
  input  logic [7:0]      MEM_ARLEN,
  input  logic [2:0]      MEM_ARSIZE,
  input  logic [1:0]      MEM_ARBURST,
  input  logic            MEM_ARVALID,
  output logic            MEM_ARREADY,
  // read data
  output logic [IW-1:0]   MEM_RID,
  output logic [DW-1:0]   MEM_RDATA,
  output logic [1:0]      MEM_RRESP,
  output logic            MEM_RLAST,
  output logic            MEM_RVALID,
  input  logic            MEM_RREADY
);

  localparam int          NB      = DW / 8;
  localparam int          OB      = $clog2(NB);
  localparam int          HI      = AW + OB;
  localparam logic [31:0] HI_MASK = ~((32'd1 << HI) - 32'd1);

  localparam logic [1:0]  BURST_FIXED = 2'b00;
  localparam logic [1:0]  BURST_WRAP  = 2'b10;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  // Address falls inside the window decoded by BASE's upper bits.
  function automatic logic f_in_range(input logic [31:0] a);
    return (a & HI_MASK) == (BASE & HI_MASK);
  endfunction

  // Reserved burst type, or WRAP with an illegal length.
  function automatic logic f_burst_err(input logic [7:0] len, input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

  // Address of the following beat; reserved burst falls through to INCR.
  function automatic logic [31:0] f_next_addr(input logic [31:0] addr, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] incr;
    logic [31:0] bnd;
    incr = 32'd1 << size;
    bnd  = ({24'd0, len} + 32'd1) << size;
    if (burst == BURST_FIXED)     return addr;
    else if (burst == BURST_WRAP) return (addr & ~(bnd - 32'd1)) | ((addr + incr) & (bnd - 32'd1));
    else                          return addr + incr;
  endfunction

  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
  typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

  logic [DW-1:0] mem_q [0:(2**AW)-1];

  // write channel state
  wstate_t       wstate_q;
  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic [IW-1:0] bid_q, aw_id_q;
  logic [31:0]   aw_addr_q;
  logic [7:0]    aw_len_q, w_cnt_q;
  logic [2:0]    aw_size_q;
  logic [1:0]    aw_burst_q;
  logic          w_err_q;

  // read channel state
  rstate_t       rstate_q;
  logic          arready_q, rvalid_q, rlast_q;
  logic [1:0]    rresp_q;
  logic [IW-1:0] rid_q;
  logic [DW-1:0] rdata_q;
  logic [31:0]   ar_addr_q;
  logic [7:0]    ar_len_q, r_cnt_q;
  logic [2:0]    ar_size_q;
  logic [1:0]    ar_burst_q;
  logic          r_err_q;

  logic          w_wr_ok, w_mem_we;
  logic [31:0]   w_rd_addr;
  logic          w_rd_ok;
  logic [DW-1:0] w_rd_word;

  assign w_wr_ok  = f_in_range(aw_addr_q);
  assign w_mem_we = (wstate_q == W_DATA) && MEM_WVALID && w_wr_ok;

  // In idle the fetch uses the incoming AR address, otherwise the next beat's.
  assign w_rd_addr = (rstate_q == R_IDLE) ? MEM_ARADDR
                   : f_next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
  assign w_rd_ok   = f_in_range(w_rd_addr);
  assign w_rd_word = mem_q[w_rd_addr[OB +: AW]];

  assign MEM_AWREADY = awready_q;
  assign MEM_WREADY  = wready_q;
  assign MEM_BVALID  = bvalid_q;
  assign MEM_BRESP   = bresp_q;
  assign MEM_BID     = bid_q;
  assign MEM_ARREADY = arready_q;
  assign MEM_RVALID  = rvalid_q;
  assign MEM_RDATA   = rdata_q;
  assign MEM_RRESP   = rresp_q;
  assign MEM_RLAST   = rlast_q;
  assign MEM_RID     = rid_q;

  // Byte-enabled memory write; contents are intentionally not reset.
  always_ff @(posedge CLK) begin
    if (w_mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (MEM_WSTRB[b]) mem_q[aw_addr_q[OB +: AW]][b*8 +: 8] <= MEM_WDATA[b*8 +: 8];
      end
    end
  end

  // Write FSM: accept AW, consume W beats until WLAST, then hold B until taken.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wstate_q   <= W_IDLE;
      awready_q  <= 1'b1;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      bid_q      <= '0;
      aw_id_q    <= '0;
      aw_addr_q  <= '0;
      aw_len_q   <= '0;
      aw_size_q  <= '0;
      aw_burst_q <= '0;
      w_cnt_q    <= '0;
      w_err_q    <= 1'b0;
    end else begin
      case (wstate_q)
        W_IDLE: begin
          if (MEM_AWVALID) begin
            aw_id_q    <= MEM_AWID;
            aw_addr_q  <= MEM_AWADDR;
            aw_len_q   <= MEM_AWLEN;
            aw_size_q  <= MEM_AWSIZE;
            aw_burst_q <= MEM_AWBURST;
            w_cnt_q    <= '0;
            w_err_q    <= f_burst_err(MEM_AWLEN, MEM_AWBURST);
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wstate_q   <= W_DATA;
          end
        end
        W_DATA: begin
          if (MEM_WVALID) begin
            aw_addr_q <= f_next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
            w_cnt_q   <= w_cnt_q + 8'd1;
            if (!w_wr_ok) w_err_q <= 1'b1;
            if (MEM_WLAST) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= aw_id_q;
              // A short or long burst (WLAST not on beat AWLEN) is an error.
              bresp_q  <= (w_err_q || !w_wr_ok || (w_cnt_q != aw_len_q)) ? RESP_SLVERR : RESP_OKAY;
              wstate_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (MEM_BREADY) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wstate_q  <= W_IDLE;
          end
        end
        default: begin
          wstate_q  <= W_IDLE;
          awready_q <= 1'b1;
          wready_q  <= 1'b0;
          bvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  // Read FSM: prefetch on AR, reload the next beat in the same cycle as each handshake.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rstate_q   <= R_IDLE;
      arready_q  <= 1'b1;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rid_q      <= '0;
      rdata_q    <= '0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      ar_size_q  <= '0;
      ar_burst_q <= '0;
      r_cnt_q    <= '0;
      r_err_q    <= 1'b0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (MEM_ARVALID) begin
            rid_q      <= MEM_ARID;
            ar_addr_q  <= MEM_ARADDR;
            ar_len_q   <= MEM_ARLEN;
            ar_size_q  <= MEM_ARSIZE;
            ar_burst_q <= MEM_ARBURST;
            r_cnt_q    <= '0;
            r_err_q    <= f_burst_err(MEM_ARLEN, MEM_ARBURST);
            rdata_q    <= w_rd_ok ? w_rd_word : '0;
            rresp_q    <= (!w_rd_ok || f_burst_err(MEM_ARLEN, MEM_ARBURST)) ? RESP_SLVERR : RESP_OKAY;
            rlast_q    <= (MEM_ARLEN == 8'd0);
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
            rstate_q   <= R_DATA;
          end
        end
        R_DATA: begin
          if (MEM_RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              rstate_q  <= R_IDLE;
            end else begin
              ar_addr_q <= w_rd_addr;
              r_cnt_q   <= r_cnt_q + 8'd1;
              rdata_q   <= w_rd_ok ? w_rd_word : '0;
              rresp_q   <= (!w_rd_ok || r_err_q) ? RESP_SLVERR : RESP_OKAY;
              rlast_q   <= ((r_cnt_q + 8'd1) == ar_len_q);
            end
          end
        end
        default: begin
          rstate_q  <= R_IDLE;
          arready_q <= 1'b1;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_full_slv_mem.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_full_slv_mem
//  Brief    : Scoreboard bench for axi_full_slv_mem (directed bursts).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_full_slv_mem;
  localparam int DW = 64;
  localparam int AW = 14;
  localparam int IW = 4;

  logic            CLK = 1'b0;
  logic            RSTn = 1'b0;
  logic [IW-1:0]   MEM_AWID = '0;
  logic [31:0]     MEM_AWADDR = '0;
  logic [7:0]      MEM_AWLEN = '0;
  logic [2:0]      MEM_AWSIZE = '0;
  logic [1:0]      MEM_AWBURST = '0;
  logic            MEM_AWVALID = 1'b0;
  logic            MEM_AWREADY;
  logic [DW-1:0]   MEM_WDATA = '0;
  logic [DW/8-1:0] MEM_WSTRB = '0;
  logic            MEM_WLAST = 1'b0;
  logic            MEM_WVALID = 1'b0;
  logic            MEM_WREADY;
  logic [IW-1:0]   MEM_BID;
  logic [1:0]      MEM_BRESP;
  logic            MEM_BVALID;
  logic            MEM_BREADY = 1'b1;
  logic [IW-1:0]   MEM_ARID = '0;
  logic [31:0]     MEM_ARADDR = '0;
  logic [7:0]      MEM_ARLEN = '0;
  logic [2:0]      MEM_ARSIZE = '0;
  logic [1:0]      MEM_ARBURST = '0;
  logic            MEM_ARVALID = 1'b0;
  logic            MEM_ARREADY;
  logic [IW-1:0]   MEM_RID;
  logic [DW-1:0]   MEM_RDATA;
  logic [1:0]      MEM_RRESP;
  logic            MEM_RLAST;
  logic            MEM_RVALID;
  logic            MEM_RREADY = 1'b1;

  axi_full_slv_mem #(.DW(DW), .AW(AW), .IW(IW), .BASE(32'h8000_0000)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .MEM_AWID(MEM_AWID), .MEM_AWADDR(MEM_AWADDR), .MEM_AWLEN(MEM_AWLEN),
    .MEM_AWSIZE(MEM_AWSIZE), .MEM_AWBURST(MEM_AWBURST),
    .MEM_AWVALID(MEM_AWVALID), .MEM_AWREADY(MEM_AWREADY),
    .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WLAST(MEM_WLAST),
    .MEM_WVALID(MEM_WVALID), .MEM_WREADY(MEM_WREADY),
    .MEM_BID(MEM_BID), .MEM_BRESP(MEM_BRESP), .MEM_BVALID(MEM_BVALID), .MEM_BREADY(MEM_BREADY),
    .MEM_ARID(MEM_ARID), .MEM_ARADDR(MEM_ARADDR), .MEM_ARLEN(MEM_ARLEN),
    .MEM_ARSIZE(MEM_ARSIZE), .MEM_ARBURST(MEM_ARBURST),
    .MEM_ARVALID(MEM_ARVALID), .MEM_ARREADY(MEM_ARREADY),
    .MEM_RID(MEM_RID), .MEM_RDATA(MEM_RDATA), .MEM_RRESP(MEM_RRESP), .MEM_RLAST(MEM_RLAST),
    .MEM_RVALID(MEM_RVALID), .MEM_RREADY(MEM_RREADY)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [IW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last; } r_exp_t;

  b_exp_t        exp_b[$];
  r_exp_t        exp_r[$];
  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            wstall = 0;
  bit            rready_mode = 1'b0;
  logic [DW-1:0] wd [16];
  logic [DW/8-1:0] ws [16];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=handshake", name);
  endtask

  task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] d, input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic do_write(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                          input logic [1:0] resp);
    b_exp_t e;
    int k;
    e.id = id; e.resp = resp;
    exp_b.push_back(e);
    @(posedge CLK); #1;
    MEM_AWID = id; MEM_AWADDR = addr; MEM_AWLEN = len; MEM_AWSIZE = size; MEM_AWBURST = burst;
    MEM_AWVALID = 1'b1;
    for (k = 0; k < 100; k++) begin @(negedge CLK); if (MEM_AWREADY) break; end
    if (k == 100) tmo("aw_ready");
    @(posedge CLK); #1;
    MEM_AWVALID = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      MEM_WDATA = wd[i]; MEM_WSTRB = ws[i]; MEM_WLAST = (i == nbeats - 1); MEM_WVALID = 1'b1;
      for (k = 0; k < 100; k++) begin @(negedge CLK); if (MEM_WREADY) break; end
      if (k == 100) tmo("w_ready");
      @(posedge CLK); #1;
    end
    MEM_WVALID = 1'b0; MEM_WLAST = 1'b0;
    for (k = 0; k < 200 && exp_b.size() != 0; k++) @(negedge CLK);
    if (exp_b.size() != 0) begin tmo("b_resp"); exp_b.delete(); end
  endtask

  task automatic do_read(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int k;
    @(posedge CLK); #1;
    MEM_ARID = id; MEM_ARADDR = addr; MEM_ARLEN = len; MEM_ARSIZE = size; MEM_ARBURST = burst;
    MEM_ARVALID = 1'b1;
    for (k = 0; k < 100; k++) begin @(negedge CLK); if (MEM_ARREADY) break; end
    if (k == 100) tmo("ar_ready");
    @(posedge CLK); #1;
    MEM_ARVALID = 1'b0;
    for (k = 0; k < 2000 && exp_r.size() != 0; k++) @(negedge CLK);
    if (exp_r.size() != 0) begin tmo("r_data"); exp_r.delete(); end
  endtask

  // RREADY driver: constant high, or toggling every cycle when requested.
  initial begin
    forever begin
      @(posedge CLK); #1;
      MEM_RREADY = rready_mode ? ~MEM_RREADY : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every B/R handshake and checks timing/stability.
  initial begin
    logic          prev_rvalid, prev_rready, prev_rlast;
    logic [DW-1:0] prev_rdata;
    logic [1:0]    prev_rresp;
    int            ar_cyc, wl_cyc;
    logic [7:0]    ar_len;
    b_exp_t        eb;
    r_exp_t        er;
    prev_rvalid = 1'b0; prev_rready = 1'b0; prev_rlast = 1'b0; prev_rdata = '0; prev_rresp = '0;
    ar_cyc = 0; wl_cyc = 0; ar_len = '0;
    forever begin
      @(negedge CLK);
      if (!RSTn) begin
        prev_rvalid = 1'b0;
      end else begin
        if (prev_rvalid && !prev_rready) begin
          check("r_stable_data", MEM_RDATA, prev_rdata);
          check("r_stable_resp", {MEM_RVALID, MEM_RLAST, MEM_RRESP}, {1'b1, prev_rlast, prev_rresp});
        end
        if (MEM_WVALID && !MEM_WREADY) wstall++;
        if (MEM_ARVALID && MEM_ARREADY) begin ar_cyc = cyc; ar_len = MEM_ARLEN; end
        if (MEM_WVALID && MEM_WREADY && MEM_WLAST) wl_cyc = cyc;
        if (MEM_BVALID && MEM_BREADY) begin
          if (exp_b.size() == 0) tmo("b_unexpected");
          else begin
            eb = exp_b.pop_front();
            check("bid", MEM_BID, eb.id);
            check("bresp", MEM_BRESP, eb.resp);
            check("b_latency", cyc - wl_cyc, 1);
          end
        end
        if (MEM_RVALID && MEM_RREADY) begin
          if (exp_r.size() == 0) tmo("r_unexpected");
          else begin
            er = exp_r.pop_front();
            check("rid", MEM_RID, er.id);
            check("rdata", MEM_RDATA, er.data);
            check("rresp", MEM_RRESP, er.resp);
            check("rlast", MEM_RLAST, er.last);
            if (MEM_RLAST && !rready_mode) check("r_latency", cyc - ar_cyc, {24'd0, ar_len} + 32'd1);
          end
        end
        prev_rvalid = MEM_RVALID; prev_rready = MEM_RREADY; prev_rlast = MEM_RLAST;
        prev_rdata = MEM_RDATA; prev_rresp = MEM_RRESP;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 8'hFF; end
    // 1: reset values
    repeat (3) @(posedge CLK);
    #2;
    check("rst_ready", {MEM_AWREADY, MEM_ARREADY}, 2'b11);
    check("rst_valid", {MEM_BVALID, MEM_RVALID, MEM_WREADY, MEM_RLAST}, 4'b0000);
    @(posedge CLK); #1; RSTn = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", {MEM_AWREADY, MEM_ARREADY, MEM_WREADY}, 3'b110);

    // 2: INCR write then INCR read with RREADY toggling
    wd[0] = 64'h1111_1111_1111_1111; wd[1] = 64'h2222_2222_2222_2222;
    wd[2] = 64'h3333_3333_3333_3333; wd[3] = 64'h4444_4444_4444_4444;
    do_write(4'd5, 32'h8000_0010, 8'd3, 3'd3, 2'b01, 4, 2'b00);
    push_r(4'd6, 64'h1111_1111_1111_1111, 2'b00, 1'b0);
    push_r(4'd6, 64'h2222_2222_2222_2222, 2'b00, 1'b0);
    push_r(4'd6, 64'h3333_3333_3333_3333, 2'b00, 1'b0);
    push_r(4'd6, 64'h4444_4444_4444_4444, 2'b00, 1'b1);
    rready_mode = 1'b1;
    do_read(4'd6, 32'h8000_0010, 8'd3, 3'd3, 2'b01);
    rready_mode = 1'b0;
    repeat (2) @(posedge CLK);

    // 3: WRAP read 0x18 -> 0x00 -> 0x08 -> 0x10, and a FIXED read
    wd[0] = 64'hA0A0_A0A0_A0A0_A0A0; wd[1] = 64'hA1A1_A1A1_A1A1_A1A1;
    do_write(4'd1, 32'h8000_0000, 8'd1, 3'd3, 2'b01, 2, 2'b00);
    push_r(4'd2, 64'h2222_2222_2222_2222, 2'b00, 1'b0);
    push_r(4'd2, 64'hA0A0_A0A0_A0A0_A0A0, 2'b00, 1'b0);
    push_r(4'd2, 64'hA1A1_A1A1_A1A1_A1A1, 2'b00, 1'b0);
    push_r(4'd2, 64'h1111_1111_1111_1111, 2'b00, 1'b1);
    do_read(4'd2, 32'h8000_0018, 8'd3, 3'd3, 2'b10);
    push_r(4'd3, 64'h2222_2222_2222_2222, 2'b00, 1'b0);
    push_r(4'd3, 64'h2222_2222_2222_2222, 2'b00, 1'b0);
    push_r(4'd3, 64'h2222_2222_2222_2222, 2'b00, 1'b1);
    do_read(4'd3, 32'h8000_0018, 8'd2, 3'd3, 2'b00);

    // 4: narrow byte write into byte 2 of word 0x10
    wd[0] = 64'hAB << 16; ws[0] = 8'h04;
    do_write(4'd7, 32'h8000_0012, 8'd0, 3'd0, 2'b01, 1, 2'b00);
    ws[0] = 8'hFF;
    push_r(4'd4, 64'h1111_1111_11AB_1111, 2'b00, 1'b1);
    do_read(4'd4, 32'h8000_0010, 8'd0, 3'd3, 2'b01);

    // 5: out-of-range write leaves memory alone; out-of-range read returns 0/SLVERR
    wd[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    do_write(4'd8, 32'h0000_0000, 8'd0, 3'd3, 2'b01, 1, 2'b10);
    push_r(4'd8, 64'hA0A0_A0A0_A0A0_A0A0, 2'b00, 1'b1);
    do_read(4'd8, 32'h8000_0000, 8'd0, 3'd3, 2'b01);
    push_r(4'd9, 64'h0, 2'b10, 1'b0);
    push_r(4'd9, 64'h0, 2'b10, 1'b1);
    do_read(4'd9, 32'h0000_0008, 8'd1, 3'd3, 2'b01);

    // reserved burst type: executes as INCR but reports SLVERR
    wd[0] = 64'h5555_5555_5555_5555;
    do_write(4'd10, 32'h8000_0040, 8'd0, 3'd3, 2'b11, 1, 2'b10);
    push_r(4'd10, 64'h5555_5555_5555_5555, 2'b00, 1'b1);
    do_read(4'd10, 32'h8000_0040, 8'd0, 3'd3, 2'b01);

    // 6: concurrent 8-beat write and read to different regions
    for (int i = 0; i < 8; i++) wd[i] = 64'h200 + 64'(i);
    do_write(4'd11, 32'h8000_0200, 8'd7, 3'd3, 2'b01, 8, 2'b00);
    for (int i = 0; i < 8; i++) wd[i] = 64'h100 + 64'(i);
    for (int i = 0; i < 8; i++) push_r(4'd13, 64'h200 + 64'(i), 2'b00, i == 7);
    wstall = 0;
    fork
      do_write(4'd12, 32'h8000_0100, 8'd7, 3'd3, 2'b01, 8, 2'b00);
      do_read(4'd13, 32'h8000_0200, 8'd7, 3'd3, 2'b01);
    join
    check("w_stall_cycles", wstall, 0);
    for (int i = 0; i < 8; i++) push_r(4'd14, 64'h100 + 64'(i), 2'b00, i == 7);
    do_read(4'd14, 32'h8000_0100, 8'd7, 3'd3, 2'b01);

    // early WLAST on beat 2 of a LEN=3 burst
    do_write(4'd15, 32'h8000_0300, 8'd3, 3'd3, 2'b01, 2, 2'b10);

    // reset in the middle of a write burst; the accepted beat stays in memory
    @(posedge CLK); #1;
    MEM_AWID = 4'd3; MEM_AWADDR = 32'h8000_0400; MEM_AWLEN = 8'd3; MEM_AWSIZE = 3'd3;
    MEM_AWBURST = 2'b01; MEM_AWVALID = 1'b1;
    @(posedge CLK); #1;
    MEM_AWVALID = 1'b0;
    MEM_WDATA = 64'hDEAD_BEEF_0000_0001; MEM_WSTRB = 8'hFF; MEM_WLAST = 1'b0; MEM_WVALID = 1'b1;
    @(posedge CLK); #1;
    MEM_WVALID = 1'b0;
    RSTn = 1'b0;
    #2;
    check("midrst_ready", {MEM_AWREADY, MEM_ARREADY}, 2'b11);
    check("midrst_valid", {MEM_WREADY, MEM_BVALID, MEM_RVALID}, 3'b000);
    @(posedge CLK); #1; RSTn = 1'b1;
    push_r(4'd1, 64'hDEAD_BEEF_0000_0001, 2'b00, 1'b1);
    do_read(4'd1, 32'h8000_0400, 8'd0, 3'd3, 2'b01);

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
